// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: groups the fetch unit's redirect, instruction-memory and decoder signals.
//   master : the fetch unit (drives IMEM_ADDR/IMEM_REQ and the decoder-side outputs)
//   slave  : the surrounding system (imem, decoder, R15 writeback)
// Signals:
//   PCSrc, Result            redirect strobe and target
//   IMEM_ADDR, IMEM_REQ      fetch address / request
//   IMEM_RDATA, IMEM_ACK     fetched word / one-cycle completion pulse
//   INSTR, INSTR_VALID       instruction to decoder and its valid
//   INSTR_READY              decoder accepts
//   PC, PC_PLUS4, PC_PLUS8   address of INSTR and its increments (PC_PLUS8 feeds R15)
//   FETCH_ERR                sticky fetch timeout flag
interface pc_fetch_unit_if;
    logic        PCSrc;
    logic [31:0] Result;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_ACK;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] PC_PLUS8;
    logic        FETCH_ERR;

    modport master (
        input  PCSrc, Result, IMEM_RDATA, IMEM_ACK, INSTR_READY,
        output IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID, PC, PC_PLUS4, PC_PLUS8, FETCH_ERR
    );

    modport slave (
        output PCSrc, Result, IMEM_RDATA, IMEM_ACK, INSTR_READY,
        input  IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID, PC, PC_PLUS4, PC_PLUS8, FETCH_ERR
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch stage.
// Issues one word fetch at a time (REQ/ACK), presents the instruction with VALID/READY, and
// supplies PC+8 for R15. A write to R15 (PCSrc) redirects fetch; a redirect that arrives while a
// fetch is outstanding is remembered and the in-flight data is dropped when it returns.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pc_fetch_unit_if.master (redirect, imem handshake, decoder handshake, PC outputs)
// Parameters:
//   RESET_VECTOR    first fetch address after reset (word aligned)
//   TIMEOUT_CYCLES  IMEM_ACK wait limit, only used with FETCH_TIMEOUT_EN
// Build option: define FETCH_TIMEOUT_EN to add the ACK timeout counter and sticky ERROR state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             rst_n,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
`ifdef FETCH_TIMEOUT_EN
        , StError
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] redir_tgt;
    logic        timeout_hit;

    assign redir_tgt = {bus.Result[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts FETCH cycles spent without ACK; any ACK or leaving FETCH restarts it.
    always_comb begin
        cnt_d = '0;
        if (state_q == StFetch && !bus.IMEM_ACK) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StFetch) && !bus.IMEM_ACK &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign timeout_hit = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
`endif

    logic unused_bits;
    assign unused_bits = ^bus.Result[1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                addr_d  = bus.PCSrc ? redir_tgt : RESET_VECTOR;
            end
            StFetch: begin
                if (bus.IMEM_ACK) begin
                    if (bus.PCSrc || pend_q) begin
                        // Data belongs to the old path: drop it and refetch at the latest target.
                        addr_d = bus.PCSrc ? redir_tgt : tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        state_d = StHold;
                        instr_d = bus.IMEM_RDATA;
                        pc_d    = addr_q;
                    end
                end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
                    state_d = StError;
`endif
                    pend_d  = 1'b0;
                end else if (bus.PCSrc) begin
                    // Request stays outstanding; remember where to go once it completes.
                    pend_d = 1'b1;
                    tgt_d  = redir_tgt;
                end
            end
            StHold: begin
                if (bus.PCSrc) begin
                    state_d = StFetch;
                    addr_d  = redir_tgt;
                end else if (bus.INSTR_READY) begin
                    state_d = StFetch;
                    addr_d  = pc_q + 32'd4;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            StError: begin
                state_d = StError;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= RESET_VECTOR;
            instr_q <= '0;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.IMEM_ADDR   = addr_q;
    assign bus.IMEM_REQ    = (state_q == StFetch);
    assign bus.INSTR       = instr_q;
    assign bus.INSTR_VALID = (state_q == StHold);
    assign bus.PC          = pc_q;
    assign bus.PC_PLUS4    = pc_q + 32'd4;
    assign bus.PC_PLUS8    = pc_q + 32'd8;
`ifdef FETCH_TIMEOUT_EN
    assign bus.FETCH_ERR   = (state_q == StError);
`else
    assign bus.FETCH_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized bench for pc_fetch_unit with a queue-based scoreboard.
// The reference model tracks only the architectural rule "the next instruction delivered is at
// the latest redirect target, otherwise at the last accepted PC + 4"; instruction memory is a
// fixed hash of the address.
module tb_pc_fetch_unit;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_VECTOR  (RV),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_deliv = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_pc = '0;
    logic        mon_en = 1'b0;
    logic        last_evt = 1'b0;
    logic        d_pcsrc = 1'b0;
    logic        d_xfer = 1'b0;
    logic [31:0] d_res = '0;
    int unsigned wait_cnt = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE3A0_1005;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2: return 32'($urandom_range(0, 255));
            default: return 32'h0000_0100 | 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.IMEM_ACK = 1'b0;
        bus.PCSrc = 1'b0;
        bus.INSTR_READY = 1'b0;
        #1;
        check("rst_req", 32'(bus.IMEM_REQ), 32'd0);
        check("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
        check("rst_instr", bus.INSTR, 32'd0);
        check("rst_addr", bus.IMEM_ADDR, RV);
        check("rst_pc", bus.PC, RV);
        check("rst_pc4", bus.PC_PLUS4, RV + 32'd4);
        check("rst_pc8", bus.PC_PLUS8, RV + 32'd8);
        check("rst_err", 32'(bus.FETCH_ERR), 32'd0);
        exp_q.delete();
        d_pcsrc = 1'b0;
        d_xfer = 1'b0;
        last_evt = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_q.push_back(RV);
        // Stray ACK during the IDLE cycle must be ignored.
        bus.IMEM_ACK = 1'b1;
        bus.IMEM_RDATA = 32'hDEAD_BEEF;
        bus.INSTR_READY = 1'b1;
        bus.PCSrc = ($urandom_range(0, 3) == 0);
        bus.Result = pick_target();
        d_pcsrc = bus.PCSrc;
        d_res = bus.Result;
        wait_cnt = $urandom_range(0, 3);
    endtask

    task automatic step();
        @(posedge clk);
        // Apply the model effect of the edge that just happened.
        last_evt = 1'b0;
        if (d_pcsrc) begin
            exp_q.delete();
            exp_q.push_back({d_res[31:2], 2'b00});
            last_evt = 1'b1;
        end else if (d_xfer) begin
            exp_q.push_back(cur_pc + 32'd4);
            last_evt = 1'b1;
        end
        #1;
        bus.INSTR_READY = ($urandom_range(0, 9) < 7);
        bus.PCSrc = ($urandom_range(0, 99) < 6);
        bus.Result = pick_target();
        if (bus.IMEM_REQ && wait_cnt == 0) begin
            bus.IMEM_ACK = 1'b1;
            bus.IMEM_RDATA = mem(bus.IMEM_ADDR);
            wait_cnt = $urandom_range(0, 3);
        end else begin
            bus.IMEM_ACK = 1'b0;
            bus.IMEM_RDATA = $urandom();
            if (bus.IMEM_REQ) wait_cnt--;
        end
        d_pcsrc = bus.PCSrc;
        d_res = bus.Result;
        d_xfer = bus.INSTR_VALID && bus.INSTR_READY;
    endtask

    // Monitor: pops an expectation each time a new instruction is presented.
    initial begin
        logic prev_valid;
        int   stall;
        prev_valid = 1'b0;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                prev_valid = 1'b0;
                stall = 0;
                continue;
            end
            check("fetch_err_low", 32'(bus.FETCH_ERR), 32'd0);
            if (last_evt) check("valid_drop", 32'(bus.INSTR_VALID), 32'd0);
            if (bus.INSTR_VALID) begin
                if (!prev_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_valid: got pc 0x%08h expected none", bus.PC);
                    end else begin
                        cur_pc = exp_q.pop_front();
                    end
                    n_deliv++;
                end
                check("pc", bus.PC, cur_pc);
                check("instr", bus.INSTR, mem(cur_pc));
                check("pc4", bus.PC_PLUS4, cur_pc + 32'd4);
                check("pc8", bus.PC_PLUS8, cur_pc + 32'd8);
                check("req_in_hold", 32'(bus.IMEM_REQ), 32'd0);
                stall = 0;
            end else begin
                stall++;
                if (stall == 64) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stall: got %0d cycles without VALID expected < 64", stall);
                    stall = 0;
                end
            end
            prev_valid = bus.INSTR_VALID;
        end
    end

    initial begin
        bus.PCSrc = 1'b0;
        bus.Result = '0;
        bus.IMEM_RDATA = '0;
        bus.IMEM_ACK = 1'b0;
        bus.INSTR_READY = 1'b0;
        do_reset();
        mon_en = 1'b1;
        repeat (2000) step();
        do_reset();
        repeat (2000) step();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("deliveries_min", 32'(n_deliv >= 200), 32'd1);
`ifdef FETCH_TIMEOUT_EN
        // Timeout: never acknowledge after reset.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.IMEM_ACK = 1'b0;
        bus.PCSrc = 1'b0;
        bus.INSTR_READY = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        check("to_req_c16", 32'(bus.IMEM_REQ), 32'd1);
        check("to_err_c16", 32'(bus.FETCH_ERR), 32'd0);
        @(posedge clk);
        #1;
        check("to_err", 32'(bus.FETCH_ERR), 32'd1);
        check("to_req", 32'(bus.IMEM_REQ), 32'd0);
        check("to_valid", 32'(bus.INSTR_VALID), 32'd0);
        bus.PCSrc = 1'b1;
        bus.Result = 32'h0000_0200;
        @(posedge clk);
        #1;
        bus.PCSrc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("to_err_sticky", 32'(bus.FETCH_ERR), 32'd1);
        check("to_req_after_pcsrc", 32'(bus.IMEM_REQ), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("to_err_cleared", 32'(bus.FETCH_ERR), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
